led_channel: RTL
================

Name: led_channel

Overview:
- Per-LED output stage sitting directly downstream of group_pwm; one instance per LED pin.
- Generates the individual 8-bit PWM at clk_400K (256-step period, about 1.5625 kHz).
- Selects the final pin drive from the 2-bit LEDOUT mode: off, on, individual PWM, or individual PWM gated by grp_pwm_signal.
- Duty and mode changes are double-buffered and applied only at period boundaries, so the output never glitches.

Parameters:
- PHASE_OFS, default 0: 8-bit phase offset added to the PWM counter before the compare. Used only when LED_PHASE_SHIFT_EN is defined.

Ports:
- clk_400K  input  1  400 kHz system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- sleep  input  1  low-power request; synchronous to clk_400K.
- invrt  input  1  output polarity; 1 = LED on when the pin is low.
- ledout_mode  input  2  00 off, 01 fully on, 10 individual PWM, 11 individual PWM AND group.
- pwm_reg  input  8  individual duty value N (N/256 on-time).
- grp_pwm_signal  input  1  group_pwm output; same clock domain.
- led_out  output  1  registered pin drive.
- period_start  output  1  one-cycle pulse aligned with the led_out sample derived from count 0.

Behaviour:
- Clocking: one clock (clk_400K). reset_n is asynchronous assert, synchronous deassert on the next clk_400K edge. Only clk_400K rising edges are used.
- Reset values: cnt = 0, duty_sh = 0, mode_sh = 00, led_out = 0, period_start = 0.
- Counter: 8-bit cnt increments every cycle and wraps 255 -> 0. It is held at 0 while sleep = 1.
- Shadow load:
  - When cnt == 255 and sleep = 0: duty_sh <= pwm_reg and mode_sh <= ledout_mode.
  - While sleep = 1: both shadows load every cycle.
  - Writes made mid-period have no effect until the next cnt == 0. A value written and rewritten within one period is never seen.
- Compare:
  - ind = (cnt_eff < duty_sh), unsigned 8-bit. cnt_eff = cnt (see Optional Feature).
  - duty 0x00 gives 0/256 (never on); 0xFF gives 255/256. 100 % on is reached only via mode 01.
- Mode select (raw = LED on):
  - 00: raw = 0
  - 01: raw = 1
  - 10: raw = ind
  - 11: raw = ind & grp_pwm_signal
- Output: led_out <= sleep ? invrt : (raw ^ invrt), registered. Latency is 1 cycle from cnt to led_out.
  - grp_pwm_signal is sampled combinationally in the same cycle; no extra sync.
- period_start: registered; high in the cycle after cnt == 0 with sleep = 0; low while sleep = 1.
- Sleep entry: takes effect on the next edge. led_out goes to the off level (= invrt) with no partial pulse completion.
- Sleep exit: the first active cycle has cnt = 0 and shadows equal to the current inputs, so the first period is full-length.
- invrt change: applied immediately on the next edge, not buffered. This is documented behaviour.
- Reset mid-period: all state is cleared asynchronously and led_out = 0 regardless of invrt until the first edge after reset release.

Optional Feature:
- Macro: LED_PHASE_SHIFT_EN.
- Defined: cnt_eff = cnt + PHASE_OFS (mod 256). Pulse edges shift by PHASE_OFS cycles relative to other channels, spreading supply current. period_start and shadow-load timing remain tied to cnt, not cnt_eff.
- Undefined: cnt_eff = cnt and PHASE_OFS is ignored.

Test Plan:
- Reset, mode 10, pwm_reg = 0x40, invrt = 0 -> led_out high for exactly 64 of every 256 cycles, starting 1 cycle after cnt = 0. period_start period = 256 cycles.
- Mode 10, pwm_reg 0x40 changed to 0xC0 at cnt = 100 -> current period keeps 64 high cycles; next period has 192 high cycles; no extra edges.
- Mode 11, pwm_reg = 0xFF, grp_pwm_signal toggled -> led_out = ind & grp; led_out held 0 while grp = 0. Modes 00 and 01 give constant 0 and 1; duty 0x00 in mode 10 gives constant 0.
- invrt = 1, mode 10, 0x80 -> led_out low for 128 cycles and high for 128. Assert sleep -> led_out = 1 next cycle and period_start stops. Deassert -> a full 128-low period begins at cnt 0.
- Assert reset_n = 0 mid-pulse -> led_out = 0 immediately (asynchronous); after release, outputs follow from cnt 0 with duty_sh = 0 until the first shadow load.
- With LED_PHASE_SHIFT_EN defined, PHASE_OFS = 64, 0x40 -> high window is cnt 192..255 (sampled), period_start unchanged. Without the macro, the window is cnt 0..63.

Source files
------------

// File: rtl/led_channel.sv
// rtl/led_channel.sv - per-LED PWM output stage with double-buffered duty/mode
//
// Purpose:
//   Generates an individual 8-bit PWM (256-step period) on clk_400K and selects
//   the final pin drive from the 2-bit LEDOUT mode. Duty and mode are held in
//   shadow registers that only update at the period boundary (or continuously
//   while sleeping), so the pin never glitches on a register write.
//
// Configuration:
//   LED_PHASE_SHIFT_EN - when defined, the PWM compare uses cnt + PHASE_OFS,
//                        shifting the pulse by PHASE_OFS cycles. When undefined,
//                        PHASE_OFS has no effect.
//
// Ports:
//   clk_400K        in   400 kHz clock, the only clock
//   reset_n         in   asynchronous active-low reset
//   sleep           in   low-power request; holds counter, forces off level
//   invrt           in   output polarity (1 = LED on when pin low)
//   ledout_mode     in   00 off, 01 on, 10 individual PWM, 11 PWM AND group
//   pwm_reg         in   individual duty N (N/256 on-time)
//   grp_pwm_signal  in   group PWM from group_pwm, same clock domain
//   led_out         out  registered pin drive
//   period_start    out  one-cycle pulse on the led_out sample from count 0

module led_channel #(
    parameter logic [7:0] PHASE_OFS = 8'd0
) (
    input  logic       clk_400K,
    input  logic       reset_n,
    input  logic       sleep,
    input  logic       invrt,
    input  logic [1:0] ledout_mode,
    input  logic [7:0] pwm_reg,
    input  logic       grp_pwm_signal,
    output logic       led_out,
    output logic       period_start
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_GROUP = 2'b11
    } mode_t;

    // Offset actually applied to the compare; zero unless phase shifting is built in.
`ifdef LED_PHASE_SHIFT_EN
    localparam logic [7:0] PHASE_APPLIED = PHASE_OFS;
`else
    localparam logic [7:0] PHASE_APPLIED = 8'd0;
`endif

    logic [7:0] cnt;
    logic [7:0] duty_sh;
    mode_t      mode_sh;
    logic [7:0] cnt_eff;
    logic       ind;
    logic       raw;
    logic       shadow_load;

    // Shadows follow the inputs continuously while asleep so that the first
    // active period after wake-up already uses the current settings.
    assign shadow_load = sleep || (cnt == 8'hFF);

    // Wraps mod 256; the period boundary and period_start stay tied to cnt.
    assign cnt_eff = cnt + PHASE_APPLIED;

    // Strict less-than: duty 0x00 never lights, 0xFF lights 255 of 256 cycles.
    assign ind = (cnt_eff < duty_sh);

    always_comb begin
        raw = 1'b0;
        unique case (mode_sh)
            MODE_OFF:   raw = 1'b0;
            MODE_ON:    raw = 1'b1;
            MODE_PWM:   raw = ind;
            MODE_GROUP: raw = ind & grp_pwm_signal;
            default:    raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk_400K or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= 8'd0;
            duty_sh      <= 8'd0;
            mode_sh      <= MODE_OFF;
            led_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (sleep) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (shadow_load) begin
                duty_sh <= pwm_reg;
                mode_sh <= mode_t'(ledout_mode);
            end

            // Sleep drops straight to the off level; no pulse is completed.
            // invrt is deliberately unbuffered and applies on the next edge.
            led_out      <= sleep ? invrt : (raw ^ invrt);
            period_start <= !sleep && (cnt == 8'd0);
        end
    end

endmodule
